// File: rtl/vx_wb_arbiter.sv
// vx_wb_arbiter: N-to-1 round-robin writeback arbiter with packet lock and a
// 2-entry registered output buffer. Define WB_ARB_PERF_EN to build the
// output back-pressure stall counter on perf_stalls (tied to 0 otherwise).
`timescale 1ns/1ps
module vx_wb_arbiter #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = 2,
  parameter int NR_BITS     = 6,
  parameter int UUID_BITS   = 44
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_INPUTS-1:0]             in_valid,
  input  logic [NUM_INPUTS*UUID_BITS-1:0]   in_uuid,
  input  logic [NUM_INPUTS*NUM_THREADS-1:0] in_tmask,
  input  logic [NUM_INPUTS*NW_BITS-1:0]     in_wid,
  input  logic [NUM_INPUTS*32-1:0]          in_PC,
  input  logic [NUM_INPUTS*NR_BITS-1:0]     in_rd,
  input  logic [NUM_INPUTS*NUM_THREADS*32-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]             in_eop,
  output logic [NUM_INPUTS-1:0]             in_ready,
  output logic                              out_valid,
  output logic [UUID_BITS-1:0]              out_uuid,
  output logic [NUM_THREADS-1:0]            out_tmask,
  output logic [NW_BITS-1:0]                out_wid,
  output logic [31:0]                       out_PC,
  output logic [NR_BITS-1:0]                out_rd,
  output logic [NUM_THREADS*32-1:0]         out_data,
  output logic                              out_eop,
  input  logic                              out_ready,
  output logic [31:0]                       perf_stalls
);

  localparam int IDX_W  = $clog2(NUM_INPUTS);
  localparam int DATA_W = NUM_THREADS * 32;

  typedef struct packed {
    logic [UUID_BITS-1:0]   uuid;
    logic [NUM_THREADS-1:0] tmask;
    logic [NW_BITS-1:0]     wid;
    logic [31:0]            pc;
    logic [NR_BITS-1:0]     rd;
    logic [DATA_W-1:0]      data;
    logic                   eop;
  } beat_t;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_e;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] lock_id_q, lock_id_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0]       count_q, count_d;
  beat_t            head_q, head_d;
  beat_t            tail_q, tail_d;

  logic             grant_any;
  logic [IDX_W-1:0] grant_idx;
  logic             push;
  logic             pop;
  beat_t            in_beat;

  // Grant selection: held on the locked channel, else first valid after rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (state_q == ARB_LOCKED) begin
      if (in_valid[lock_id_q]) begin
        grant_any = 1'b1;
        grant_idx = lock_id_q;
      end
    end else begin
      for (int unsigned k = 1; k <= NUM_INPUTS; k++) begin
        if (!grant_any && in_valid[IDX_W'((32'(rr_ptr_q) + k) % NUM_INPUTS)]) begin
          grant_any = 1'b1;
          grant_idx = IDX_W'((32'(rr_ptr_q) + k) % NUM_INPUTS);
        end
      end
    end
  end

  // Ready only to the granted channel while the buffer has room.
  always_comb begin
    in_ready = '0;
    if (!reset && count_q != 2'd2) in_ready[grant_idx] = grant_any;
  end

  assign push = grant_any && (count_q != 2'd2) && !reset;
  assign pop  = out_valid && out_ready;

  // Sideband mux of the granted channel's beat.
  always_comb begin
    in_beat.uuid  = in_uuid [grant_idx*UUID_BITS   +: UUID_BITS];
    in_beat.tmask = in_tmask[grant_idx*NUM_THREADS +: NUM_THREADS];
    in_beat.wid   = in_wid  [grant_idx*NW_BITS     +: NW_BITS];
    in_beat.pc    = in_PC   [grant_idx*32          +: 32];
    in_beat.rd    = in_rd   [grant_idx*NR_BITS     +: NR_BITS];
    in_beat.data  = in_data [grant_idx*DATA_W      +: DATA_W];
    in_beat.eop   = in_eop  [grant_idx];
  end

  // Arbitration state: pointer advances and lock follows eop on each input transfer.
  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (push) begin
      rr_ptr_d = grant_idx;
      if (in_beat.eop) begin
        state_d = ARB_OPEN;
      end else begin
        state_d   = ARB_LOCKED;
        lock_id_d = grant_idx;
      end
    end
  end

  // Two-slot buffer: head is always the output register, tail holds the second beat.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_beat;
        else                 tail_d = in_beat;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        if (count_q == 2'd2) head_d = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // count is 1 here (push needs count<2, pop needs count>0) unless count is 2,
        // which blocks push; so simultaneous push/pop just replaces the head.
        if (count_q == 2'd1) begin
          head_d = in_beat;
        end else begin
          head_d = tail_q;
          tail_d = in_beat;
        end
      end
      default: ;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_OPEN;
      lock_id_q <= '0;
      rr_ptr_q  <= IDX_W'(NUM_INPUTS - 1);
      count_q   <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_uuid  = head_q.uuid;
  assign out_tmask = head_q.tmask;
  assign out_wid   = head_q.wid;
  assign out_PC    = head_q.pc;
  assign out_rd    = head_q.rd;
  assign out_data  = head_q.data;
  assign out_eop   = head_q.eop;

`ifdef WB_ARB_PERF_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of cycles the sink holds off a valid head beat.
  always_comb begin
    perf_d = perf_q;
    if (out_valid && !out_ready && perf_q != '1) perf_d = perf_q + 32'd1;
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_stalls = perf_q;
`else
  assign perf_stalls = '0;
`endif

endmodule
